// File: rtl/otter_mem_hs.sv
`timescale 1ns/1ps
// OTTER unified memory: sync instruction read port plus handshaked data port with memory-mapped IO.
// Latency: instruction 1 cycle; memory load VALID2 RD_LAT cycles after accept; IO load 1 cycle after IO_ACK.
// Backpressure: BUSY2 only while an IO transaction or its return is pending; memory ops never stall.
module otter_mem_hs #(
    parameter int          WORD_ADDR_BITS = 14,
    parameter logic [31:0] IO_BASE        = 32'h00010000,
    parameter int          RD_LAT         = 1,
    parameter              INIT_FILE      = "otter_memory.mem"
) (
    input  logic                      MEM_CLK,
    input  logic                      MEM_RST_N,
    input  logic                      MEM_RDEN1,
    input  logic [WORD_ADDR_BITS-1:0] MEM_ADDR1,
    output logic [31:0]               MEM_DOUT1,
    input  logic                      MEM_REQ2,
    input  logic                      MEM_WE2,
    input  logic [31:0]               MEM_ADDR2,
    input  logic [31:0]               MEM_DIN2,
    input  logic [1:0]                MEM_SIZE,
    input  logic                      MEM_SIGN,
    output logic                      MEM_BUSY2,
    output logic                      MEM_VALID2,
    output logic [31:0]               MEM_DOUT2,
    output logic                      MEM_ERR,
    input  logic                      MEM_ERR_CLR,
    input  logic [31:0]               IO_IN,
    input  logic                      IO_ACK,
    output logic                      IO_WR,
    output logic                      IO_RD,
    output logic [31:0]               IO_ADDR,
    output logic [31:0]               IO_DOUT
);
    localparam int DEPTH = 1 << WORD_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, IO_WAIT, IO_RET} state_t;
    typedef struct packed {
        logic       vld;
        logic       zero;
        logic [1:0] size;
        logic       sign;
        logic [1:0] off;
    } ld_t;

    logic [31:0] mem [DEPTH];

    state_t                    state, state_nx;
    logic                      acc, mis, is_io, in_rng, mem_we, io_start;
    logic [1:0]                off;
    logic [3:0]                be;
    logic [31:0]               wdat, rd_word, f_word, ld_dat, cur, io_cap, dout_hold;
    logic [WORD_ADDR_BITS-1:0] widx;
    ld_t                       s1, f;

    assign off       = MEM_ADDR2[1:0];
    assign widx      = MEM_ADDR2[WORD_ADDR_BITS+1:2];
    assign is_io     = (MEM_ADDR2 >= IO_BASE);
    assign in_rng    = (MEM_ADDR2[31:WORD_ADDR_BITS+2] == '0);
    assign MEM_BUSY2 = (state != IDLE);
    assign acc       = MEM_REQ2 && !MEM_BUSY2;
    assign mem_we    = acc && MEM_WE2 && !mis && !is_io && in_rng;
    assign io_start  = acc && !mis && is_io;
    assign wdat      = MEM_DIN2 << {off, 3'b000};

    always_comb begin
        mis = 1'b0;
        be  = 4'b0000;
        case (MEM_SIZE)
            2'd0: be = 4'b0001 << off;
            2'd1: begin be = 4'b0011 << off; mis = (off == 2'd3); end
            2'd2: begin be = 4'b1111; mis = (off != 2'd0); end
            default: mis = 1'b1;
        endcase
    end

    // Read-first: the read samples the array before this edge's byte-lane write lands.
    always_ff @(posedge MEM_CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
        rd_word <= mem[widx];
    end

    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N)     MEM_DOUT1 <= '0;
        else if (MEM_RDEN1) MEM_DOUT1 <= mem[MEM_ADDR1];
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
                if (!MEM_RST_N) f <= '0;
                else            f <= s1;
            end
            always_ff @(posedge MEM_CLK) f_word <= rd_word;
        end else begin : g_lat1
            assign f      = s1;
            assign f_word = rd_word;
        end
    endgenerate

    always_comb begin
        ld_dat = f_word;
        case (f.size)
            2'd0: ld_dat = {{24{~f.sign & f_word[{f.off, 3'b000} + 5'd7]}},  f_word[{f.off, 3'b000} +: 8]};
            2'd1: ld_dat = {{16{~f.sign & f_word[{f.off, 3'b000} + 5'd15]}}, f_word[{f.off, 3'b000} +: 16]};
            default: ld_dat = f_word;
        endcase
        if (f.zero) ld_dat = '0;
    end

    assign MEM_VALID2 = f.vld || (state == IO_RET);
    assign cur        = (state == IO_RET) ? io_cap : ld_dat;
    assign MEM_DOUT2  = MEM_VALID2 ? cur : dout_hold;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (io_start) state_nx = IO_WAIT;
            IO_WAIT: if (IO_ACK) state_nx = IO_RD ? IO_RET : IDLE;
            IO_RET:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) state <= IDLE;
        else            state <= state_nx;
    end

    // Misaligned loads (memory or IO range) ride the memory pipeline and return zero.
    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            s1        <= '0;
            IO_WR     <= 1'b0;
            IO_RD     <= 1'b0;
            IO_ADDR   <= '0;
            IO_DOUT   <= '0;
            io_cap    <= '0;
            dout_hold <= '0;
            MEM_ERR   <= 1'b0;
        end else begin
            s1.vld <= acc && !MEM_WE2 && (mis || !is_io);
            if (acc) begin
                s1.zero <= mis || !in_rng;
                s1.size <= MEM_SIZE;
                s1.sign <= MEM_SIGN;
                s1.off  <= off;
            end
            if (io_start) begin
                IO_ADDR <= MEM_ADDR2;
                IO_DOUT <= MEM_DIN2;
                IO_WR   <= MEM_WE2;
                IO_RD   <= !MEM_WE2;
            end else if (state == IO_WAIT && IO_ACK) begin
                IO_WR <= 1'b0;
                IO_RD <= 1'b0;
                if (IO_RD) io_cap <= IO_IN;
            end
            if (MEM_VALID2) dout_hold <= cur;
            if (acc && mis)       MEM_ERR <= 1'b1;
            else if (MEM_ERR_CLR) MEM_ERR <= 1'b0;
        end
    end
endmodule

// File: tb/tb_otter_mem_hs.sv
`timescale 1ns/1ps
// Scoreboard bench for otter_mem_hs (RD_LAT = 2): loads push expected data and due cycle,
// a monitor pops on every VALID2; IO and error sequencing checked inline.
module tb_otter_mem_hs;
    localparam int WAB = 10;
    localparam int LAT = 2;

    logic           MEM_CLK = 1'b0;
    logic           MEM_RST_N;
    logic           MEM_RDEN1;
    logic [WAB-1:0] MEM_ADDR1;
    logic [31:0]    MEM_DOUT1;
    logic           MEM_REQ2, MEM_WE2, MEM_SIGN, MEM_ERR_CLR, IO_ACK;
    logic [31:0]    MEM_ADDR2, MEM_DIN2, IO_IN;
    logic [1:0]     MEM_SIZE;
    logic           MEM_BUSY2, MEM_VALID2, MEM_ERR, IO_WR, IO_RD;
    logic [31:0]    MEM_DOUT2, IO_ADDR, IO_DOUT;

    otter_mem_hs #(.WORD_ADDR_BITS(WAB), .IO_BASE(32'h00010000), .RD_LAT(LAT), .INIT_FILE("")) dut (
        .MEM_CLK(MEM_CLK), .MEM_RST_N(MEM_RST_N),
        .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .MEM_DOUT1(MEM_DOUT1),
        .MEM_REQ2(MEM_REQ2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_BUSY2(MEM_BUSY2), .MEM_VALID2(MEM_VALID2),
        .MEM_DOUT2(MEM_DOUT2), .MEM_ERR(MEM_ERR), .MEM_ERR_CLR(MEM_ERR_CLR),
        .IO_IN(IO_IN), .IO_ACK(IO_ACK), .IO_WR(IO_WR), .IO_RD(IO_RD),
        .IO_ADDR(IO_ADDR), .IO_DOUT(IO_DOUT)
    );

    always #5 MEM_CLK = ~MEM_CLK;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    always @(posedge MEM_CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Called at a negedge; drives one request and returns at the negedge after its accept edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sg, input logic [31:0] exp, input bit io);
        int t = 0;
        while (MEM_BUSY2 && t < 20) begin
            @(negedge MEM_CLK);
            t++;
        end
        if (t == 20) chk("busy_timeout", {31'd0, MEM_BUSY2}, 32'd0);
        MEM_REQ2  = 1'b1;
        MEM_WE2   = we;
        MEM_ADDR2 = a;
        MEM_DIN2  = d;
        MEM_SIZE  = sz;
        MEM_SIGN  = sg;
        if (!we) sb_q.push_back('{exp, io ? 0 : cyc + LAT});
        @(negedge MEM_CLK);
        MEM_REQ2 = 1'b0;
        MEM_WE2  = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        issue(1'b1, a, d, sz, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [31:0] exp);
        issue(1'b0, a, 32'd0, sz, sg, exp, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge MEM_CLK);
            if (MEM_RST_N && MEM_VALID2) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, MEM_VALID2}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ld_data", MEM_DOUT2, e.dat);
                    if (e.due != 0) chk("ld_latency", cyc, e.due);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d checks so far)", n_chk);
        $fatal(1);
    end

    initial begin : stim
        MEM_RST_N = 1'b0; MEM_RDEN1 = 1'b0; MEM_ADDR1 = '0; MEM_REQ2 = 1'b0; MEM_WE2 = 1'b0;
        MEM_ADDR2 = '0; MEM_DIN2 = '0; MEM_SIZE = '0; MEM_SIGN = 1'b0; MEM_ERR_CLR = 1'b0;
        IO_IN = '0; IO_ACK = 1'b0;
        repeat (2) @(negedge MEM_CLK);
        chk("rst_flags", {27'd0, MEM_BUSY2, MEM_VALID2, MEM_ERR, IO_WR, IO_RD}, 32'd0);
        chk("rst_dout1", MEM_DOUT1, 32'd0);
        chk("rst_dout2", MEM_DOUT2, 32'd0);
        chk("rst_io_bus", IO_ADDR | IO_DOUT, 32'd0);
        MEM_RST_N = 1'b1;
        @(negedge MEM_CLK);

        // Sizing and extension on one word
        st(32'h100, 32'hDEADBEEF, 2'd2);
        ld(32'h103, 2'd0, 1'b0, 32'hFFFFFFDE);
        ld(32'h101, 2'd0, 1'b1, 32'h000000BE);
        ld(32'h102, 2'd1, 1'b0, 32'hFFFFDEAD);
        ld(32'h101, 2'd1, 1'b1, 32'h0000ADBE);
        ld(32'h100, 2'd2, 1'b0, 32'hDEADBEEF);
        st(32'h100, 32'h00000077, 2'd0);
        st(32'h101, 32'h0000CAFE, 2'd1);
        ld(32'h100, 2'd2, 1'b0, 32'hDECAFE77);

        // Instruction port: read-first, then hold while disabled
        MEM_RDEN1 = 1'b1;
        MEM_ADDR1 = 10'h040;
        st(32'h100, 32'h11223344, 2'd2);
        chk("if_read_first", MEM_DOUT1, 32'hDECAFE77);
        @(negedge MEM_CLK);
        chk("if_new_word", MEM_DOUT1, 32'h11223344);
        MEM_RDEN1 = 1'b0;
        st(32'h100, 32'h55555555, 2'd2);
        @(negedge MEM_CLK);
        chk("if_hold", MEM_DOUT1, 32'h11223344);

        // Back-to-back pipelined loads
        for (int i = 0; i < 4; i++) st(32'h300 + 32'(4 * i), 32'hA0000000 + 32'(i), 2'd2);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_busy", {31'd0, MEM_BUSY2}, 32'd0);
            ld(32'h300 + 32'(4 * i), 2'd2, 1'b0, 32'hA0000000 + 32'(i));
        end

        // Hole between memory top and IO base
        st(32'h0, 32'h13579BDF, 2'd2);
        st(32'h1000, 32'hFFFFFFFF, 2'd2);
        ld(32'h1000, 2'd2, 1'b0, 32'h0);
        ld(32'h0, 2'd2, 1'b0, 32'h13579BDF);
        chk("hole_no_err", {31'd0, MEM_ERR}, 32'd0);

        // Misalignment and sticky error
        st(32'h200, 32'h0BADF00D, 2'd2);
        st(32'h203, 32'h0000FFFF, 2'd1);
        chk("mis_err_set", {31'd0, MEM_ERR}, 32'd1);
        ld(32'h200, 2'd2, 1'b0, 32'h0BADF00D);
        MEM_ERR_CLR = 1'b1;
        ld(32'h202, 2'd2, 1'b0, 32'h0);
        MEM_ERR_CLR = 1'b0;
        chk("err_set_wins", {31'd0, MEM_ERR}, 32'd1);
        MEM_ERR_CLR = 1'b1;
        @(negedge MEM_CLK);
        MEM_ERR_CLR = 1'b0;
        chk("err_clr", {31'd0, MEM_ERR}, 32'd0);
        st(32'h00010002, 32'h1, 2'd2);
        chk("mis_io_no_strobe", {30'd0, IO_WR, IO_RD}, 32'd0);
        chk("mis_io_err", {31'd0, MEM_ERR}, 32'd1);
        MEM_ERR_CLR = 1'b1;
        @(negedge MEM_CLK);
        MEM_ERR_CLR = 1'b0;

        // IO store with ack in the third wait cycle
        st(32'h00010004, 32'hA5A50001, 2'd2);
        chk("io_wr_addr", IO_ADDR, 32'h00010004);
        chk("io_wr_data", IO_DOUT, 32'hA5A50001);
        for (int i = 0; i < 3; i++) begin
            chk("io_wr_hold", {30'd0, IO_WR, MEM_BUSY2}, 32'd3);
            if (i == 2) IO_ACK = 1'b1;
            @(negedge MEM_CLK);
        end
        IO_ACK = 1'b0;
        chk("io_wr_drop", {30'd0, IO_WR, MEM_BUSY2}, 32'd0);

        // IO load
        issue(1'b0, 32'h00010000, 32'd0, 2'd2, 1'b0, 32'h12345678, 1'b1);
        chk("io_rd_strobe", {31'd0, IO_RD}, 32'd1);
        chk("io_rd_addr", IO_ADDR, 32'h00010000);
        IO_ACK = 1'b1;
        IO_IN  = 32'h12345678;
        @(negedge MEM_CLK);
        IO_ACK = 1'b0;
        IO_IN  = 32'h0;
        chk("io_ret", {29'd0, MEM_VALID2, MEM_BUSY2, IO_RD}, 32'd6);
        @(negedge MEM_CLK);
        chk("io_ret_done", {30'd0, MEM_VALID2, MEM_BUSY2}, 32'd0);
        chk("dout2_held", MEM_DOUT2, 32'h12345678);

        // Stray ack while idle
        IO_ACK = 1'b1;
        IO_IN  = 32'hBAD0BAD0;
        @(negedge MEM_CLK);
        IO_ACK = 1'b0;
        chk("idle_ack_ignored", {29'd0, MEM_VALID2, MEM_BUSY2, IO_RD}, 32'd0);

        // IO load issued behind an in-flight memory load
        ld(32'h304, 2'd2, 1'b0, 32'hA0000001);
        issue(1'b0, 32'h0001000C, 32'd0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1);
        IO_ACK = 1'b1;
        IO_IN  = 32'hCAFEF00D;
        @(negedge MEM_CLK);
        IO_ACK = 1'b0;
        @(negedge MEM_CLK);

        // Asynchronous reset during IO_WAIT
        issue(1'b0, 32'h0, 32'd0, 2'd3, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h00010008, 32'd0, 2'd2, 1'b0, 32'h0, 1'b1);
        chk("pre_rst_io_rd", {30'd0, IO_RD, MEM_ERR}, 32'd3);
        #2 MEM_RST_N = 1'b0;
        #1 chk("async_rst_io_rd", {30'd0, IO_RD, MEM_BUSY2}, 32'd0);
        sb_q.delete(sb_q.size() - 1);
        @(negedge MEM_CLK);
        MEM_RST_N = 1'b1;
        chk("post_rst", {29'd0, MEM_BUSY2, MEM_VALID2, MEM_ERR}, 32'd0);
        ld(32'h0, 2'd2, 1'b0, 32'h13579BDF);

        repeat (5) @(negedge MEM_CLK);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
